// File: rtl/zport_waitreq.sv
// Z80 I/O wait request front end: synchronises the strobes, decodes gluclock and COM-port
// accesses, latches the access and sequences wait_start / wait_end with a stuck-wait watchdog.
//
// state | meaning
// IDLE  | waiting for a matching I/O access
// PEND  | access latched, waiting for avr_done or the watchdog
// HOLD  | wait released, waiting for the Z80 to finish the I/O cycle
module zport_waitreq #(
    parameter logic [15:0] GLUCLOCK_PORT = 16'hBFF7,
    parameter logic [7:0]  COM_LO        = 8'hEF,
    parameter logic [4:0]  COM_HI_MASK   = 5'b11111,
    parameter int          TO_W          = 12
) (
    input  logic        fclk,
    input  logic        rst_n,
    input  logic [15:0] za,
    input  logic [7:0]  zd_in,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        wr_n,
    input  logic        m1_n,
    input  logic        gluclock_ena,
    input  logic        comport_ena,
    input  logic        avr_done,
    output logic        wait_start_gluclock,
    output logic        wait_start_comport,
    output logic        wait_end,
    output logic [15:0] wait_addr,
    output logic        wait_rnw,
    output logic [7:0]  wait_wrdata,
    output logic        busy,
    output logic        timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      iorq_sr, rd_sr, wr_sr, m1_sr;
    logic            iorq_s, rd_s, wr_s, m1_s;
    logic            io_act, io_act_d, io_start;
    logic [TO_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic            glu, com, tc, latch_en;
    logic            start_glu_nxt, start_com_nxt, end_nxt, to_nxt;

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            iorq_sr <= 2'b11;
            rd_sr   <= 2'b11;
            wr_sr   <= 2'b11;
            m1_sr   <= 2'b11;
        end else begin
            iorq_sr <= {iorq_sr[0], iorq_n};
            rd_sr   <= {rd_sr[0], rd_n};
            wr_sr   <= {wr_sr[0], wr_n};
            m1_sr   <= {m1_sr[0], m1_n};
        end
    end

    assign iorq_s = iorq_sr[1];
    assign rd_s   = rd_sr[1];
    assign wr_s   = wr_sr[1];
    assign m1_s   = m1_sr[1];

    // M1 low with IORQ is an interrupt acknowledge, never a port access
    assign io_act = ~iorq_s & (~rd_s | ~wr_s) & m1_s;

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            io_act_d <= 1'b0;
            io_start <= 1'b0;
        end else begin
            io_act_d <= io_act;
            io_start <= io_act & ~io_act_d;
        end
    end

    assign glu     = (za == GLUCLOCK_PORT) & gluclock_ena;
    assign com     = (za[7:0] == COM_LO) & (za[15:11] == COM_HI_MASK) & comport_ena;
    assign cnt_inc = cnt + {{(TO_W-1){1'b0}}, 1'b1};
    // fires on the edge that brings the counter to all-ones, i.e. after 2**TO_W-1 PEND cycles
    assign tc      = &cnt_inc;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        latch_en      = 1'b0;
        start_glu_nxt = 1'b0;
        start_com_nxt = 1'b0;
        end_nxt       = 1'b0;
        to_nxt        = 1'b0;
        case (state)
            IDLE: begin
                if (io_start && (glu || com)) begin
                    latch_en      = 1'b1;
                    start_glu_nxt = glu;
                    start_com_nxt = ~glu & com;
                    cnt_nxt       = '0;
                    state_nxt     = PEND;
                end
            end
            PEND: begin
                cnt_nxt = cnt_inc;
                if (avr_done) begin
                    end_nxt   = 1'b1;
                    state_nxt = HOLD;
                end else if (tc) begin
                    end_nxt   = 1'b1;
                    to_nxt    = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!io_act) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            cnt                 <= '0;
            wait_start_gluclock <= 1'b0;
            wait_start_comport  <= 1'b0;
            wait_end            <= 1'b0;
            timeout             <= 1'b0;
        end else begin
            state               <= state_nxt;
            cnt                 <= cnt_nxt;
            wait_start_gluclock <= start_glu_nxt;
            wait_start_comport  <= start_com_nxt;
            wait_end            <= end_nxt;
            timeout             <= to_nxt;
        end
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            wait_addr   <= '0;
            wait_rnw    <= 1'b0;
            wait_wrdata <= '0;
        end else if (latch_en) begin
            wait_addr   <= za;
            wait_rnw    <= ~rd_s;
            wait_wrdata <= zd_in;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_zport_waitreq.sv
// Bench for zport_waitreq: table of directed accesses, randomized accesses checked against
// a transaction-level timing model, and hand sequences for reset and stray avr_done strobes.
module tb_zport_waitreq;

    localparam int TO_W = 5;
    localparam int TMAX = (1 << TO_W) - 1;

    logic        fclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] za = '0;
    logic [7:0]  zd_in = '0;
    logic        iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, m1_n = 1'b1;
    logic        gluclock_ena = 1'b0, comport_ena = 1'b0, avr_done = 1'b0;
    logic        wait_start_gluclock, wait_start_comport, wait_end, wait_rnw, busy, timeout;
    logic [15:0] wait_addr;
    logic [7:0]  wait_wrdata;

    zport_waitreq #(.TO_W(TO_W)) dut (
        .fclk(fclk), .rst_n(rst_n), .za(za), .zd_in(zd_in),
        .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .m1_n(m1_n),
        .gluclock_ena(gluclock_ena), .comport_ena(comport_ena), .avr_done(avr_done),
        .wait_start_gluclock(wait_start_gluclock), .wait_start_comport(wait_start_comport),
        .wait_end(wait_end), .wait_addr(wait_addr), .wait_rnw(wait_rnw),
        .wait_wrdata(wait_wrdata), .busy(busy), .timeout(timeout)
    );

    always #5 fclk = ~fclk;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic        rnw;
        logic        glu_en;
        logic        com_en;
        logic        m1_n;
        int          k;          // avr_done delay after wait_start, -1 = never
        logic        hold_done;  // extra avr_done while in HOLD
        logic        exp_glu;
        logic        exp_com;
        logic        exp_to;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_addr = '0;
    logic        exp_rnw = 1'b0;
    logic [7:0]  exp_wd = '0;
    vec_t        tbl[9];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic vec_t ref_model(input vec_t v);
        vec_t r = v;
        r.exp_glu = v.m1_n && v.glu_en && (v.addr == 16'hBFF7);
        r.exp_com = v.m1_n && v.com_en && (v.addr[7:0] == 8'hEF) && (v.addr[15:11] == 5'h1F)
                    && !r.exp_glu;
        r.exp_to  = (r.exp_glu || r.exp_com) && !(v.k >= 0 && v.k <= TMAX - 1);
        return r;
    endfunction

    // Cycle c counts negedges from the strobe falling edge (c=0). Outputs are sampled at each
    // negedge before that cycle's inputs are driven.
    task automatic run_txn(input vec_t v, input string tag);
        int   exp_e, exp_t, r, n, gpos, cpos, epos, tpos, bcnt, bfirst;
        logic hit;
        hit = v.exp_glu | v.exp_com;
        if (!hit) begin
            exp_e = -1;
            exp_t = -1;
        end else if (v.exp_to) begin
            exp_e = 4 + TMAX;
            exp_t = exp_e;
        end else begin
            exp_e = 5 + v.k;
            exp_t = -1;
        end
        r = hit ? exp_e + 2 + int'($urandom_range(0, 3)) : 6 + int'($urandom_range(0, 4));
        n = r + 6;
        gpos = -1; cpos = -1; epos = -1; tpos = -1; bcnt = 0; bfirst = -1;

        @(negedge fclk);
        za = v.addr;
        zd_in = v.data;
        gluclock_ena = v.glu_en;
        comport_ena = v.com_en;
        m1_n = v.m1_n;
        for (int c = 0; c < n; c++) begin
            @(negedge fclk);
            if (wait_start_gluclock) gpos = (gpos == -1) ? c : -2;
            if (wait_start_comport)  cpos = (cpos == -1) ? c : -2;
            if (wait_end)            epos = (epos == -1) ? c : -2;
            if (timeout)             tpos = (tpos == -1) ? c : -2;
            if (busy) begin
                bcnt++;
                if (bfirst == -1) bfirst = c;
            end
            if (c == 0) begin
                iorq_n = 1'b0;
                if (v.rnw) rd_n = 1'b0;
                else       wr_n = 1'b0;
            end
            if (c == 6) begin
                gluclock_ena = 1'($urandom);
                comport_ena = 1'($urandom);
            end
            if (c == r) begin
                iorq_n = 1'b1;
                rd_n = 1'b1;
                wr_n = 1'b1;
            end
            avr_done = (v.k >= 0 && c == 4 + v.k) || (hit && v.hold_done && c == exp_e + 1);
        end
        avr_done = 1'b0;
        m1_n = 1'b1;

        if (hit) begin
            exp_addr = v.addr;
            exp_rnw = v.rnw;
            exp_wd = v.data;
        end
        check({tag, "_start_glu_cycle"}, gpos, v.exp_glu ? 4 : -1);
        check({tag, "_start_com_cycle"}, cpos, v.exp_com ? 4 : -1);
        check({tag, "_wait_end_cycle"}, epos, exp_e);
        check({tag, "_timeout_cycle"}, tpos, exp_t);
        check({tag, "_busy_first"}, bfirst, hit ? 4 : -1);
        check({tag, "_busy_cycles"}, bcnt, hit ? r - 1 : 0);
        check({tag, "_wait_addr"}, int'(wait_addr), int'(exp_addr));
        check({tag, "_wait_rnw"}, int'(wait_rnw), int'(exp_rnw));
        if (!exp_rnw) check({tag, "_wait_wrdata"}, int'(wait_wrdata), int'(exp_wd));
    endtask

    initial begin
        vec_t v;
        int   cnt;

        tbl[0] = '{16'hBFF7, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 10,       1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{16'hF8EF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 20,       1'b0, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{16'h00EF, 8'h11, 1'b1, 1'b1, 1'b1, 1'b1, 5,        1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{16'hBFF7, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 5,        1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{16'hBFF7, 8'h33, 1'b1, 1'b1, 1'b0, 1'b1, -1,       1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{16'hF8EF, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, TMAX - 1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{16'hBFF7, 8'h44, 1'b1, 1'b1, 1'b1, 1'b0, 3,        1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{16'hBFF7, 8'h66, 1'b1, 1'b1, 1'b0, 1'b1, 0,        1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8] = '{16'hFFEF, 8'h77, 1'b0, 1'b1, 1'b1, 1'b1, TMAX - 2, 1'b0, 1'b0, 1'b1, 1'b0};

        #3;
        check("reset_outputs", int'({wait_start_gluclock, wait_start_comport, wait_end, timeout,
                                     busy, wait_rnw, wait_addr, wait_wrdata}), 0);
        @(negedge fclk);
        rst_n = 1'b1;
        repeat (3) @(negedge fclk);

        for (int i = 0; i < 9; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // stray avr_done while idle
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge fclk);
            if (wait_end || busy) cnt++;
            avr_done = (c < 4);
        end
        avr_done = 1'b0;
        check("idle_avr_done_ignored", cnt, 0);

        // reset in the middle of PEND
        @(negedge fclk);
        za = 16'hBFF7; zd_in = 8'hC3; gluclock_ena = 1'b1; comport_ena = 1'b0; m1_n = 1'b1;
        @(negedge fclk);
        iorq_n = 1'b0; wr_n = 1'b0;
        repeat (8) @(negedge fclk);
        check("pend_before_reset_busy", int'(busy), 1);
        #2;
        rst_n = 1'b0; iorq_n = 1'b1; wr_n = 1'b1;
        #1;
        check("reset_mid_pend", int'({wait_start_gluclock, wait_start_comport, wait_end, timeout,
                                      busy, wait_rnw, wait_addr, wait_wrdata}), 0);
        @(negedge fclk);
        rst_n = 1'b1;
        exp_addr = '0; exp_rnw = 1'b0; exp_wd = '0;
        repeat (3) @(negedge fclk);
        run_txn(tbl[0], "after_reset");

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0:       v.addr = 16'hBFF7;
                1:       v.addr = {5'h1F, 3'($urandom), 8'hEF};
                2:       v.addr = {5'($urandom), 3'($urandom), 8'hEF};
                3:       v.addr = 16'h00EF;
                default: v.addr = 16'($urandom);
            endcase
            v.data = 8'($urandom);
            v.rnw = 1'($urandom);
            v.glu_en = ($urandom_range(0, 3) != 0);
            v.com_en = ($urandom_range(0, 3) != 0);
            v.m1_n = ($urandom_range(0, 7) != 0);
            v.k = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, TMAX + 4)) : -1;
            v.hold_done = 1'($urandom);
            v = ref_model(v);
            run_txn(v, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
